pipe_trace_tracker: RTL

- Synthesizable, parametrised instruction-lifetime tracker for an N-stage in-order pipeline.
- Carries a metadata record alongside each pipeline stage:
  - sequence tag;
  - fetch cycle stamp;
  - accumulated stall count.
- Honours per-stage stall and flush vectors.
- Emits one registered retire record per instruction that leaves the last stage.
- Sits beside the CPU pipeline and is driven by the hazard unit's stall/flush signals. Feeds the testbench and on-chip debug.

---
 rtl/pipe_trace_tracker_if.sv | 53 +++++
 rtl/pipe_trace_tracker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_trace_tracker_if.sv
// Signal bundle between pipe_trace_tracker and its pipeline/debug neighbours.
// Defining PIPE_TRACE_PERF_CNT_EN adds the perf counter outputs.
interface pipe_trace_tracker_if #(
  parameter int NUM_STAGES = 5,
  parameter int TAG_W      = 8,
  parameter int CYC_W      = 32,
  parameter int STALL_W    = 4
);
  // Fetch handshake: an instruction is accepted on a rising edge where
  // fetch_valid && fetch_ready; fetch_ready never depends on fetch_valid,
  // and an offer that is not accepted leaves no trace and consumes no tag.
  logic                        fetch_valid;
  logic                        fetch_ready;
  logic [NUM_STAGES-1:0]       stall_vec;
  logic [NUM_STAGES-1:0]       flush_vec;
  logic [NUM_STAGES-1:0]       stage_valid;
  logic [NUM_STAGES*TAG_W-1:0] stage_tag;
  logic                        retire_valid;
  logic [TAG_W-1:0]            retire_tag;
  logic [CYC_W-1:0]            retire_fetch_cyc;
  logic [CYC_W-1:0]            retire_lat;
  logic [STALL_W-1:0]          retire_stalls;
  logic [CYC_W-1:0]            cycle_cnt;
`ifdef PIPE_TRACE_PERF_CNT_EN
  logic [31:0]                 perf_retired;
  logic [31:0]                 perf_flushed;
  logic [31:0]                 perf_stall_cyc;

  modport master (
    input  fetch_valid, stall_vec, flush_vec,
    output fetch_ready, stage_valid, stage_tag, retire_valid, retire_tag,
           retire_fetch_cyc, retire_lat, retire_stalls, cycle_cnt,
           perf_retired, perf_flushed, perf_stall_cyc
  );
  modport slave (
    output fetch_valid, stall_vec, flush_vec,
    input  fetch_ready, stage_valid, stage_tag, retire_valid, retire_tag,
           retire_fetch_cyc, retire_lat, retire_stalls, cycle_cnt,
           perf_retired, perf_flushed, perf_stall_cyc
  );
`else
  modport master (
    input  fetch_valid, stall_vec, flush_vec,
    output fetch_ready, stage_valid, stage_tag, retire_valid, retire_tag,
           retire_fetch_cyc, retire_lat, retire_stalls, cycle_cnt
  );
  modport slave (
    output fetch_valid, stall_vec, flush_vec,
    input  fetch_ready, stage_valid, stage_tag, retire_valid, retire_tag,
           retire_fetch_cyc, retire_lat, retire_stalls, cycle_cnt
  );
`endif
endinterface

// File: rtl/pipe_trace_tracker.sv
// Instruction-lifetime tracker riding beside an N-stage in-order pipeline.
// Optional perf counters are built when PIPE_TRACE_PERF_CNT_EN is defined.
module pipe_trace_tracker #(
  parameter int NUM_STAGES = 5,
  parameter int TAG_W      = 8,
  parameter int CYC_W      = 32,
  parameter int STALL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_trace_tracker_if.master  bus
);
  localparam int LAST = NUM_STAGES - 1;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] hold;
  logic [TAG_W-1:0]      tag_q    [NUM_STAGES];
  logic [CYC_W-1:0]      fcyc_q   [NUM_STAGES];
  logic [STALL_W-1:0]    stalls_q [NUM_STAGES];
  logic [TAG_W-1:0]      tag_cnt_q;
  logic [CYC_W-1:0]      cycle_q;
  logic                  fetch_ready;
  logic                  accept;
  logic                  retire_fire;

  logic                  ret_valid_q;
  logic [TAG_W-1:0]      ret_tag_q;
  logic [CYC_W-1:0]      ret_fcyc_q;
  logic [CYC_W-1:0]      ret_lat_q;
  logic [STALL_W-1:0]    ret_stalls_q;

  // A stall freezes its own stage and everything upstream of it.
  always_comb begin
    hold = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      hold[i] = |(bus.stall_vec >> i);
    end
  end

  assign fetch_ready = ~hold[0] & ~bus.flush_vec[0];
  assign accept      = bus.fetch_valid & fetch_ready;
  assign retire_fire = valid_q[LAST] & ~bus.stall_vec[LAST] & ~bus.flush_vec[LAST];

  // A flushed stage kills the record it currently holds, so the stage below
  // receives a bubble instead of that record.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      tag_cnt_q <= '0;
      cycle_q   <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        tag_q[i]    <= '0;
        fcyc_q[i]   <= '0;
        stalls_q[i] <= '0;
      end
    end else begin
      cycle_q <= cycle_q + CYC_W'(1);
      if (accept) tag_cnt_q <= tag_cnt_q + TAG_W'(1);

      if (bus.flush_vec[0]) begin
        valid_q[0] <= 1'b0;
      end else if (hold[0]) begin
        if (valid_q[0] && stalls_q[0] != STALL_MAX) stalls_q[0] <= stalls_q[0] + STALL_W'(1);
      end else begin
        valid_q[0]  <= bus.fetch_valid;
        tag_q[0]    <= tag_cnt_q;
        fcyc_q[0]   <= cycle_q;
        stalls_q[0] <= '0;
      end

      for (int i = 1; i < NUM_STAGES; i++) begin
        if (bus.flush_vec[i]) begin
          valid_q[i] <= 1'b0;
        end else if (hold[i]) begin
          if (valid_q[i] && stalls_q[i] != STALL_MAX) stalls_q[i] <= stalls_q[i] + STALL_W'(1);
        end else if (hold[i-1]) begin
          valid_q[i] <= 1'b0;
        end else begin
          valid_q[i]  <= valid_q[i-1] & ~bus.flush_vec[i-1];
          tag_q[i]    <= tag_q[i-1];
          fcyc_q[i]   <= fcyc_q[i-1];
          stalls_q[i] <= stalls_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_valid_q  <= 1'b0;
      ret_tag_q    <= '0;
      ret_fcyc_q   <= '0;
      ret_lat_q    <= '0;
      ret_stalls_q <= '0;
    end else begin
      ret_valid_q <= retire_fire;
      if (retire_fire) begin
        ret_tag_q    <= tag_q[LAST];
        ret_fcyc_q   <= fcyc_q[LAST];
        ret_lat_q    <= cycle_q - fcyc_q[LAST];
        ret_stalls_q <= stalls_q[LAST];
      end
    end
  end

  assign bus.fetch_ready      = fetch_ready;
  assign bus.stage_valid      = valid_q;
  assign bus.retire_valid     = ret_valid_q;
  assign bus.retire_tag       = ret_tag_q;
  assign bus.retire_fetch_cyc = ret_fcyc_q;
  assign bus.retire_lat       = ret_lat_q;
  assign bus.retire_stalls    = ret_stalls_q;
  assign bus.cycle_cnt        = cycle_q;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_tag
    assign bus.stage_tag[g*TAG_W +: TAG_W] = tag_q[g];
  end

`ifdef PIPE_TRACE_PERF_CNT_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_flushed_q;
  logic [31:0] perf_stall_q;
  logic [31:0] flush_pop;

  always_comb begin
    flush_pop = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      flush_pop = flush_pop + 32'(valid_q[i] & bus.flush_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flushed_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_q + 32'(retire_fire);
      perf_flushed_q <= perf_flushed_q + flush_pop;
      perf_stall_q   <= perf_stall_q + 32'(|bus.stall_vec);
    end
  end

  assign bus.perf_retired   = perf_retired_q;
  assign bus.perf_flushed   = perf_flushed_q;
  assign bus.perf_stall_cyc = perf_stall_q;
`endif
endmodule
